// File: rtl/micro_sequencer.sv
// ============================================================================
// micro_sequencer : microprogrammed sequencer with dispatch table and call stack
// Rev 1.0
// ============================================================================
`default_nettype none

module micro_sequencer #(
  parameter int    OPCODE_W    = 5,
  parameter int    FLAG_W      = 8,
  parameter int    UADDR_W     = 6,
  parameter int    SIG_W       = 32,
  parameter int    STACK_DEPTH = 4,
  parameter string UPROG_FILE  = "microprogram_clean.mem",
  localparam int   FSEL_W      = (FLAG_W > 1) ? $clog2(FLAG_W) : 1,
  localparam int   SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FLAG_W-1:0]   flags,
  input  logic                disp_we,
  input  logic [OPCODE_W-1:0] disp_addr,
  input  logic [UADDR_W-1:0]  disp_data,
  output logic [SIG_W-1:0]    signals,
  output logic [UADDR_W-1:0]  upc,
  output logic [SP_W-1:0]     sp,
  output logic                err
);

  localparam int WORD_W = UADDR_W + 3 + FSEL_W + 1 + SIG_W;
  localparam int SIDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [2:0] MODE_GOTO = 3'b000;
  localparam logic [2:0] MODE_SEQ  = 3'b001;
  localparam logic [2:0] MODE_COND = 3'b010;
  localparam logic [2:0] MODE_DISP = 3'b011;
  localparam logic [2:0] MODE_CALL = 3'b100;
  localparam logic [2:0] MODE_RET  = 3'b101;

  logic [WORD_W-1:0]  ustore   [2**UADDR_W];
  logic [UADDR_W-1:0] disp_tbl [2**OPCODE_W];

  logic [WORD_W-1:0]  cur_q, cur_d;
  logic [UADDR_W-1:0] upc_q, upc_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic               err_q, err_d;
  logic [UADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [UADDR_W-1:0] stack_d [STACK_DEPTH];

  logic [UADDR_W-1:0] next_addr;
  logic [2:0]         mode;
  logic [FSEL_W-1:0]  fsel;
  logic               fpol;
  logic [UADDR_W-1:0] nxt, upc_inc;
  logic               push, pop, err_set, cond_taken;
  logic [SIDX_W-1:0]  top_idx, push_idx;

  assign next_addr = cur_q[WORD_W-1 -: UADDR_W];
  assign mode      = cur_q[SIG_W+1+FSEL_W +: 3];
  assign fsel      = cur_q[SIG_W+1 +: FSEL_W];
  assign fpol      = cur_q[SIG_W];
  assign upc_inc   = upc_q + 1'b1;
  assign top_idx   = SIDX_W'(sp_q - 1'b1);
  assign push_idx  = SIDX_W'(sp_q);

  assign signals = cur_q[SIG_W-1:0];
  assign upc     = upc_q;
  assign sp      = sp_q;
  assign err     = err_q;

  always_comb begin
    nxt        = '0;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    cond_taken = 1'b0;
    // A select beyond the flag bus reads as an implicit zero flag.
    if (32'(fsel) < FLAG_W) cond_taken = (flags[fsel] == fpol);
    else                    cond_taken = ~fpol;
    case (mode)
      MODE_GOTO: nxt = next_addr;
      MODE_SEQ:  nxt = upc_inc;
      MODE_COND: nxt = cond_taken ? next_addr : upc_inc;
      MODE_DISP: nxt = disp_tbl[opcode];
      MODE_CALL: begin
        nxt = next_addr;
        if (sp_q < SP_FULL) push = 1'b1;
        else                err_set = 1'b1;
      end
      MODE_RET: begin
        if (sp_q != '0) begin
          nxt = stack_q[top_idx];
          pop = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
      default: err_set = 1'b1;
    endcase
  end

  always_comb begin
    cur_d   = cur_q;
    upc_d   = upc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    stack_d = stack_q;
    if (!stall) begin
      cur_d = ustore[nxt];
      upc_d = nxt;
      err_d = err_q | err_set;
      if (push) begin
        stack_d[push_idx] = upc_inc;
        sp_d              = sp_q + 1'b1;
      end else if (pop) begin
        sp_d = sp_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      upc_q <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      upc_q <= upc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack payload needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && disp_we) disp_tbl[disp_addr] <= disp_data;
  end

endmodule

`default_nettype wire
